// File: rtl/apx_div16by8.sv
// Approximate 16/8 unsigned restoring divider, one quotient bit per cycle.
// TRUNC drops that many quotient LSBs; valid range is 0..4 only.
module apx_div16by8 #(
  parameter int TRUNC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        dz,
  output logic        ovf,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] ITER  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] K = 4'(8 - TRUNC);

  logic [1:0]  state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  qacc_q, qacc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  remo_q, remo_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  trial;
  logic [8:0]  rem_nx;
  logic [7:0]  qacc_nx;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qacc_d  = qacc_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    // One restoring step: bring down the next dividend bit and try to subtract.
    trial   = {rem_q[7:0], dvd_q[7]};
    if (trial >= {1'b0, dvs_q}) begin
      rem_nx  = trial - {1'b0, dvs_q};
      qacc_nx = {qacc_q[6:0], 1'b1};
    end else begin
      rem_nx  = trial;
      qacc_nx = {qacc_q[6:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q == 8'd0) begin
          dz_d    = 1'b1;
          quo_d   = 8'hFF;
          remo_d  = 8'd0;
          state_d = DONE;
        end else if (dvd_q[15:8] >= dvs_q) begin
          ovf_d   = 1'b1;
          quo_d   = 8'hFF;
          remo_d  = 8'd0;
          state_d = DONE;
        end else begin
          rem_d   = {1'b0, dvd_q[15:8]};
          qacc_d  = 8'd0;
          cnt_d   = K;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d        = rem_nx;
        qacc_d       = qacc_nx;
        dvd_d[7:0]   = {dvd_q[6:0], 1'b0};
        cnt_d        = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          quo_d   = qacc_nx << TRUNC;
          remo_d  = rem_nx[7:0];
          state_d = DONE;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qacc_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qacc_q  <= qacc_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule
